// File: rtl/mrelbp_pkg.sv
// Shared constants for the radius-6 MRELBP column generator.
package mrelbp_pkg;

    // Rows in one vertical sampling column (radius 6 -> 2*6+1).
    localparam int NUM_ROWS        = 13;
    // Line buffers needed to delay the current row back to the oldest row.
    localparam int NUM_LINE_BUFS   = NUM_ROWS - 1;
    // First row whose column is fully populated with pixels of this frame.
    localparam int FIRST_VALID_ROW = NUM_ROWS - 1;
    // Default pixel width and image dimensions.
    localparam int DATA_W          = 8;
    localparam int IMG_WIDTH_DEF   = 32;
    localparam int IMG_HEIGHT_DEF  = 32;

endpackage : mrelbp_pkg

// File: rtl/mrelbp_line_buffer.sv
// Enabled line buffer: dout presents the sample written exactly DEPTH
// enabled cycles earlier. Storage is deliberately not reset; consumers gate
// stale contents with their own valid logic.
module mrelbp_line_buffer #(
    parameter int DEPTH  = 32,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DEPTH-1:0][DATA_W-1:0] shift_r;

    // Shift a new sample in on each enabled cycle; hold otherwise.
    always_ff @(posedge clk) begin
        if (en) begin
            shift_r <= {shift_r[DEPTH-2:0], din};
        end else begin
            shift_r <= shift_r;
        end
    end

    assign dout = shift_r[DEPTH-1];

endmodule : mrelbp_line_buffer

// File: rtl/mrelbp_col_gen_r6.sv
// Radius-6 column generator: turns a raster pixel stream into 13-pixel
// vertical columns (S1 oldest row .. S13 current row) using 12 cascaded
// line buffers, with registered valid and end-of-frame flags.
module mrelbp_col_gen_r6 #(
    parameter int IMG_WIDTH  = mrelbp_pkg::IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT = mrelbp_pkg::IMG_HEIGHT_DEF,
    parameter int DATA_W     = mrelbp_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              done_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              done_o,
    output logic [DATA_W-1:0] S1,
    output logic [DATA_W-1:0] S2,
    output logic [DATA_W-1:0] S3,
    output logic [DATA_W-1:0] S4,
    output logic [DATA_W-1:0] S5,
    output logic [DATA_W-1:0] S6,
    output logic [DATA_W-1:0] S7,
    output logic [DATA_W-1:0] S8,
    output logic [DATA_W-1:0] S9,
    output logic [DATA_W-1:0] S10,
    output logic [DATA_W-1:0] S11,
    output logic [DATA_W-1:0] S12,
    output logic [DATA_W-1:0] S13,
    output logic              progress_done_o
);

    import mrelbp_pkg::*;

    localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [ROW_W-1:0] ROW_VALID = ROW_W'(FIRST_VALID_ROW);

    logic [COL_W-1:0]  col_r;
    logic [ROW_W-1:0]  row_r;
    logic [COL_W-1:0]  col_nxt_s;
    logic [ROW_W-1:0]  row_nxt_s;
    logic              col_last_s;
    logic              row_last_s;
    logic              valid_row_s;
    logic              done_r;
    logic              progress_r;

    // tap[0] is the current row, tap[k] is the same column k rows earlier.
    logic [DATA_W-1:0] tap_s  [NUM_ROWS];
    // column_r[0] drives S1 (oldest) .. column_r[12] drives S13 (current).
    logic [DATA_W-1:0] column_r [NUM_ROWS];

    assign tap_s[0] = data_i;

    genvar gk;
    generate
        for (gk = 1; gk <= NUM_LINE_BUFS; gk++) begin : g_lbuf
            mrelbp_line_buffer #(
                .DEPTH  (IMG_WIDTH),
                .DATA_W (DATA_W)
            ) u_lbuf (
                .clk  (clk),
                .en   (done_i),
                .din  (tap_s[gk-1]),
                .dout (tap_s[gk])
            );
        end
    endgenerate

    // Raster position bookkeeping: next column/row and frame-position flags.
    always_comb begin
        col_last_s  = (col_r == COL_LAST);
        row_last_s  = (row_r == ROW_LAST);
        valid_row_s = (row_r >= ROW_VALID);
        if (col_last_s) begin
            col_nxt_s = {COL_W{1'b0}};
            if (row_last_s) begin
                row_nxt_s = {ROW_W{1'b0}};
            end else begin
                row_nxt_s = row_r + ROW_W'(1);
            end
        end else begin
            col_nxt_s = col_r + COL_W'(1);
            row_nxt_s = row_r;
        end
    end

    // Position counters advance only on accepted pixels; reset wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_r <= {COL_W{1'b0}};
            row_r <= {ROW_W{1'b0}};
        end else if (done_i) begin
            col_r <= col_nxt_s;
            row_r <= row_nxt_s;
        end else begin
            col_r <= col_r;
            row_r <= row_r;
        end
    end

    // Valid and end-of-frame flags: one cycle after each accepted pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_r     <= 1'b0;
            progress_r <= 1'b0;
        end else if (done_i) begin
            done_r     <= valid_row_s;
            progress_r <= valid_row_s & row_last_s & col_last_s;
        end else begin
            done_r     <= 1'b0;
            progress_r <= 1'b0;
        end
    end

    // Column register: capture only for fully valid columns, hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_ROWS; k++) begin
                column_r[k] <= {DATA_W{1'b0}};
            end
        end else if (done_i && valid_row_s) begin
            for (int k = 0; k < NUM_ROWS; k++) begin
                column_r[k] <= tap_s[NUM_ROWS-1-k];
            end
        end else begin
            for (int k = 0; k < NUM_ROWS; k++) begin
                column_r[k] <= column_r[k];
            end
        end
    end

    assign done_o          = done_r;
    assign progress_done_o = progress_r;
    assign S1  = column_r[0];
    assign S2  = column_r[1];
    assign S3  = column_r[2];
    assign S4  = column_r[3];
    assign S5  = column_r[4];
    assign S6  = column_r[5];
    assign S7  = column_r[6];
    assign S8  = column_r[7];
    assign S9  = column_r[8];
    assign S10 = column_r[9];
    assign S11 = column_r[10];
    assign S12 = column_r[11];
    assign S13 = column_r[12];

endmodule : mrelbp_col_gen_r6

// File: tb/tb_mrelbp_col_gen_r6.sv
// Directed scoreboard bench for the radius-6 column generator (16x16 image).
module tb_mrelbp_col_gen_r6;

    localparam int W  = 16;
    localparam int H  = 16;
    localparam int DW = 8;
    localparam int VW = 2 + 13 * DW;

    logic          clk;
    logic          rst;
    logic          done_i;
    logic [DW-1:0] data_i;
    logic          done_o;
    logic          progress_done_o;
    logic [DW-1:0] S1, S2, S3, S4, S5, S6, S7, S8, S9, S10, S11, S12, S13;

    mrelbp_col_gen_r6 #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .DATA_W     (DW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .done_i          (done_i),
        .data_i          (data_i),
        .done_o          (done_o),
        .S1 (S1), .S2 (S2), .S3 (S3), .S4 (S4), .S5 (S5), .S6 (S6), .S7 (S7),
        .S8 (S8), .S9 (S9), .S10 (S10), .S11 (S11), .S12 (S12), .S13 (S13),
        .progress_done_o (progress_done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int m_row = 0;
    int m_col = 0;
    logic [DW-1:0] held [1:13];
    logic [VW-1:0] sb [$];

    function automatic logic [DW-1:0] pix(input int r, input int c);
        return DW'((r * 16 + c) % 256);
    endfunction

    function automatic logic [VW-1:0] pack_exp(input logic d, input logic p);
        logic [VW-1:0] v;
        v = {d, p, held[1], held[2], held[3], held[4], held[5], held[6], held[7],
             held[8], held[9], held[10], held[11], held[12], held[13]};
        return v;
    endfunction

    // One clock: drive inputs, push the model's expectation, compare after the edge.
    task automatic step(input logic v, input logic r_in);
        logic [VW-1:0] e;
        logic [VW-1:0] obs;
        logic first_col;
        logic last_pix;
        int pr;
        int pc;
        first_col = 1'b0;
        last_pix  = 1'b0;
        pr = m_row;
        pc = m_col;
        rst    = r_in;
        done_i = v;
        data_i = (v && !r_in) ? pix(m_row, m_col) : DW'($urandom_range(0, 255));
        if (r_in) begin
            for (int k = 1; k <= 13; k++) held[k] = 8'h00;
            sb.push_back(pack_exp(1'b0, 1'b0));
            m_row = 0;
            m_col = 0;
        end else if (v) begin
            if (m_row >= 12) begin
                for (int k = 1; k <= 13; k++) held[k] = pix(m_row - 13 + k, m_col);
                first_col = (m_row == 12) && (m_col == 0);
                last_pix  = (m_row == H - 1) && (m_col == W - 1);
                sb.push_back(pack_exp(1'b1, last_pix));
            end else begin
                sb.push_back(pack_exp(1'b0, 1'b0));
            end
            m_col = m_col + 1;
            if (m_col == W) begin
                m_col = 0;
                m_row = (m_row == H - 1) ? 0 : m_row + 1;
            end
        end else begin
            sb.push_back(pack_exp(1'b0, 1'b0));
        end
        @(posedge clk);
        #1;
        obs = {done_o, progress_done_o, S1, S2, S3, S4, S5, S6, S7, S8, S9, S10, S11, S12, S13};
        e = sb.pop_front();
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL outputs r=%0d c=%0d v=%0b rst=%0b observed=%h expected=%h",
                   pr, pc, v, r_in, obs, e);
        end
        if (done_o) done_cnt++;
        if (first_col) begin
            checks++;
            assert ({S1, S7, S13} === {8'd0, 8'd96, 8'd192}) else begin
                errors++;
                $error("FAIL first_col observed=%h expected=%h", {S1, S7, S13}, {8'd0, 8'd96, 8'd192});
            end
        end
        if (last_pix) begin
            checks++;
            assert ({progress_done_o, S1, S13} === {1'b1, 8'd63, 8'd255}) else begin
                errors++;
                $error("FAIL last_pix observed=%h expected=%h", {progress_done_o, S1, S13},
                       {1'b1, 8'd63, 8'd255});
            end
        end
    endtask

    task automatic check_count(input string tag);
        checks++;
        assert (done_cnt === 64) else begin
            errors++;
            $error("FAIL %s done_o count observed=%0d expected=64", tag, done_cnt);
        end
        done_cnt = 0;
    endtask

    initial begin
        rst    = 1'b1;
        done_i = 1'b0;
        data_i = 8'h00;
        for (int k = 1; k <= 13; k++) held[k] = 8'h00;

        // Reset state.
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        done_cnt = 0;

        // Frame 1: continuous valid.
        for (int i = 0; i < W * H; i++) step(1'b1, 1'b0);
        check_count("frame1");

        // Frame 2 back-to-back, valid low every other cycle.
        for (int i = 0; i < W * H; i++) begin
            step(1'b1, 1'b0);
            step(1'b0, 1'b0);
        end
        check_count("frame2_stall");

        // Frame 3 back-to-back, abandoned by reset at pixel (13,5).
        for (int i = 0; i < 13 * W + 5; i++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        checks++;
        assert ({done_o, progress_done_o, S1, S13} === {1'b0, 1'b0, 8'd0, 8'd0}) else begin
            errors++;
            $error("FAIL mid_reset observed=%h expected=0", {done_o, progress_done_o, S1, S13});
        end

        // Reset concurrent with a valid 0xAA pixel: the pixel is dropped.
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        rst    = 1'b1;
        done_i = 1'b1;
        data_i = 8'hAA;
        @(posedge clk);
        #1;
        m_row = 0;
        m_col = 0;
        for (int k = 1; k <= 13; k++) held[k] = 8'h00;
        checks++;
        assert ({done_o, S13} === {1'b0, 8'd0}) else begin
            errors++;
            $error("FAIL reset_with_pixel observed=%h expected=0", {done_o, S13});
        end

        // Full frame after restart: first done_o after the new (12,0).
        done_cnt = 0;
        for (int i = 0; i < W * H; i++) step(1'b1, 1'b0);
        check_count("restart_frame");
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mrelbp_col_gen_r6
